// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths, operand pair type and feeder FSM states
package booth_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } operand_pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/booth_op_fifo.sv
// rtl/booth_op_fifo.sv - circular operand FIFO, power-of-two depth, sync active-high reset
module booth_op_fifo
  import booth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  operand_pair_t push_data,
  input  logic          pop,
  output operand_pair_t pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  operand_pair_t mem_q [DEPTH];
  operand_pair_t mem_d [DEPTH];
  logic          push_en;
  logic          pop_en;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so increment overflow is the modulo-DEPTH wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/booth_operand_feeder.sv
// rtl/booth_operand_feeder.sv - queues operand pairs, launches one Booth multiply at a time, holds result
// Optional FEEDER_STATS_EN adds a 16-bit op_count of accepted results.
module booth_operand_feeder
  import booth_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              start,
  output logic [PROD_W-1:0] INBUS,
  input  logic [PROD_W-1:0] OUTBUS,
  output logic              res_valid,
  output logic [PROD_W-1:0] res_data,
  input  logic              res_ready,
`ifdef FEEDER_STATS_EN
  output logic [15:0]       op_count,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_LAUNCH = LAUNCH;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_HOLD   = HOLD;

  localparam int              CNT_W    = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [PROD_W-1:0] inbus_q, inbus_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [PROD_W-1:0] res_data_q, res_data_d;

  operand_pair_t     fifo_wr_data;
  operand_pair_t     fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              res_hs;

  assign fifo_wr_data = '{a: in_a, b: in_b};
  assign in_ready     = !fifo_full;
  assign fifo_push    = in_valid && in_ready;
  assign res_hs       = res_valid_q && res_ready;

  booth_op_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (fifo_push),
    .push_data (fifo_wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // INBUS is only loaded on launch, so it stays put through WAIT until the capture.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    inbus_d     = inbus_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          inbus_d  = fifo_rd_data;
          start_d  = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        start_d = 1'b0;
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_data_d  = OUTBUS;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (res_hs) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      inbus_q     <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      inbus_q     <= inbus_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign start     = start_q;
  assign INBUS     = inbus_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

`ifdef FEEDER_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (res_hs) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_booth_operand_feeder.sv
// tb/tb_booth_operand_feeder.sv - scoreboard bench for booth_operand_feeder with behavioural multiplier
module tb_booth_operand_feeder;

  localparam int DEPTH = 4;
  localparam int L     = 10;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        start;
  logic [15:0] INBUS;
  logic [15:0] OUTBUS;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_ready = 1'b1;
  logic        busy;
`ifdef FEEDER_STATS_EN
  logic [15:0] op_count;
`endif

  booth_operand_feeder #(
    .DEPTH       (DEPTH),
    .MUL_LATENCY (L)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .start     (start),
    .INBUS     (INBUS),
    .OUTBUS    (OUTBUS),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
`ifdef FEEDER_STATS_EN
    .op_count  (op_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product valid on OUTBUS exactly L cycles after start.
  logic signed [15:0] mdl_sa, mdl_sb;
  logic [15:0]        mdl_prod = '0;
  int                 mdl_cnt  = 0;
  assign mdl_sa = {{8{INBUS[15]}}, INBUS[15:8]};
  assign mdl_sb = {{8{INBUS[7]}}, INBUS[7:0]};
  always @(posedge clk) begin
    if (rst_b) begin
      mdl_cnt <= 0;
    end else if (start) begin
      mdl_cnt  <= L;
      mdl_prod <= mdl_sa * mdl_sb;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end
  assign OUTBUS = (mdl_cnt == 1) ? mdl_prod : 16'hxxxx;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [15:0] exp_in_q [$];
  logic [15:0] exp_res_q [$];
  int          start_mark = -1;
  int          valid_mark = -1;

  // Monitor: pops the scoreboard on every launch and every result handshake.
  logic        prev_start = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [15:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst_b) begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (start) begin
        if (start_mark < 0) start_mark = cyc;
        check16("start_not_double", 16'(prev_start), 16'h0000);
        if (exp_in_q.size() == 0) check16("unexpected_start", 16'(start), 16'h0000);
        else check16("inbus_at_start", INBUS, exp_in_q.pop_front());
      end
      if (res_valid) begin
        if (valid_mark < 0) valid_mark = cyc;
        if (prev_valid && !prev_hs) check16("res_data_stable", res_data, prev_data);
        if (res_ready) begin
          if (exp_res_q.size() == 0) check16("unexpected_result", 16'(res_valid), 16'h0000);
          else check16("res_data", res_data, exp_res_q.pop_front());
        end
      end
      prev_start = start;
      prev_valid = res_valid;
      prev_hs    = res_valid && res_ready;
      prev_data  = res_data;
    end
  end

  // Caller is aligned to a negedge; returns at the negedge after the accepting edge.
  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_int("push_accept_timeout", int'(k < 200), 1);
    exp_in_q.push_back({a, b});
    exp_res_q.push_back(p);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp_res_q.size() != 0 || busy || res_valid) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_int(name, int'(k < 1000), 1);
  endtask

  task automatic check_reset_vals();
    check16("rst_start", 16'(start), 16'h0000);
    check16("rst_inbus", INBUS, 16'h0000);
    check16("rst_res_valid", 16'(res_valid), 16'h0000);
    check16("rst_res_data", res_data, 16'h0000);
    check16("rst_in_ready", 16'(in_ready), 16'h0001);
    check16("rst_busy", 16'(busy), 16'h0000);
  endtask

  logic [7:0]  wa [10] = '{8'h02, 8'hFF, 8'h10, 8'h05, 8'h7F, 8'h80, 8'h0A, 8'hF6, 8'h20, 8'hC0};
  logic [7:0]  wb [10] = '{8'h03, 8'hFF, 8'hF0, 8'h05, 8'h80, 8'h7F, 8'h0B, 8'h0A, 8'h04, 8'hC0};
  logic [15:0] wp [10] = '{16'h0006, 16'h0001, 16'hFF00, 16'h0019, 16'hC080,
                           16'hC080, 16'h006E, 16'hFF9C, 16'h0080, 16'h1000};

  initial begin
    int n;
    int seen;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    check_reset_vals();

    // Single pair with timing.
    start_mark = -1;
    valid_mark = -1;
    push_pair(8'h4A, 8'hC1, 16'hEDCA);
    n = cyc;
    drain("drain_single");
    check_int("start_cycle", start_mark, n + 1);
    check_int("res_valid_cycle", valid_mark, n + 2 + L);

    // Signed corners.
    push_pair(8'h7F, 8'h7F, 16'h3F01);
    push_pair(8'h80, 8'h80, 16'h4000);
    push_pair(8'hFF, 8'h01, 16'hFFFF);
    push_pair(8'h00, 8'h5A, 16'h0000);
    drain("drain_corners");

    // Backpressure: one launched, four queued, FIFO full.
    res_ready = 1'b0;
    push_pair(8'h01, 8'h02, 16'h0002);
    push_pair(8'h03, 8'h04, 16'h000C);
    push_pair(8'hFE, 8'h05, 16'hFFF6);
    push_pair(8'h10, 8'h10, 16'h0100);
    push_pair(8'h81, 8'h02, 16'hFF02);
    check16("full_in_ready", 16'(in_ready), 16'h0000);
    check16("full_busy", 16'(busy), 16'h0001);
    repeat (L + 8) @(negedge clk);
    check16("hold_res_valid", 16'(res_valid), 16'h0001);
    check16("hold_res_data", res_data, 16'h0002);
    check16("hold_in_ready", 16'(in_ready), 16'h0000);
    res_ready = 1'b1;
    drain("drain_backpressure");

    // Push coincident with the IDLE->LAUNCH pop.
    push_pair(8'h06, 8'h07, 16'h002A);
    push_pair(8'hF9, 8'h03, 16'hFFEB);
    check16("simul_push_pop_count", 16'(dut.u_fifo.count_q), 16'h0001);
    drain("drain_simul");

    // Ten pairs to wrap the pointers.
    for (int i = 0; i < 10; i++) push_pair(wa[i], wb[i], wp[i]);
    drain("drain_wrap");

    // Reset mid-WAIT with two pairs queued.
    push_pair(8'h11, 8'h22, 16'h0242);
    push_pair(8'h33, 8'h44, 16'h0D8C);
    push_pair(8'h55, 8'h66, 16'h21DE);
    rst_b = 1'b1;
    exp_in_q.delete();
    exp_res_q.delete();
    @(negedge clk);
    rst_b = 1'b0;
    check_reset_vals();
    seen = 0;
    repeat (L + 10) begin
      @(negedge clk);
      if (res_valid || start) seen++;
    end
    check_int("no_output_after_reset", seen, 0);
    push_pair(8'h03, 8'h05, 16'h000F);
    drain("drain_after_reset");

`ifdef FEEDER_STATS_EN
    push_pair(8'h01, 8'h01, 16'h0001);
    push_pair(8'h02, 8'h02, 16'h0004);
    drain("drain_stats");
    check16("op_count_three", op_count, 16'h0003);
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    push_pair(8'h02, 8'h03, 16'h0006);
    drain("drain_wrap_count");
    check16("op_count_wrap", op_count, 16'h0000);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
